// File: rtl/image_mem_arbiter.sv
// Image memory arbiter: shares the single-port on-chip image memory between
// the VGA pixel-read path, the SDRAM loader write path and HPS pixel writes.
// VGA normally wins. A writer that has been refused STARVE_LIMIT cycles in a
// row beats VGA. Loader and HPS take turns through a round-robin pointer.
// The grant and the memory address, data and write enable are all registered
// on the same edge. Read data comes back to VGA two cycles after its grant.
module image_mem_arbiter #(
  parameter int ADDR_W       = 9,
  parameter int DATA_W       = 24,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clk50,
  input  logic              reset,

  input  logic              vga_req,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic              vga_gnt,
  output logic [DATA_W-1:0] vga_rdata,
  output logic              vga_rvalid,

  input  logic              ld_req,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic              ld_gnt,

  input  logic              hps_req,
  input  logic [ADDR_W-1:0] hps_addr,
  input  logic [DATA_W-1:0] hps_wdata,
  output logic              hps_gnt,

  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout,

  output logic              vga_stall
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  // Which requester owns the memory slot decided at the coming edge.
  typedef enum logic [1:0] {
    SEL_NONE,
    SEL_VGA,
    SEL_LD,
    SEL_HPS
  } sel_t;

  // Which writer wins the next writer-versus-writer tie.
  typedef enum logic {
    RR_LD,
    RR_HPS
  } rr_t;

  sel_t sel;
  logic ld_starved;
  logic hps_starved;

  rr_t              rr_q,      rr_d;
  logic [CNT_W-1:0] ld_cnt_q,  ld_cnt_d;
  logic [CNT_W-1:0] hps_cnt_q, hps_cnt_d;

  logic              vga_gnt_q, vga_gnt_d;
  logic              ld_gnt_q,  ld_gnt_d;
  logic              hps_gnt_q, hps_gnt_d;
  logic [ADDR_W-1:0] mem_a_q,   mem_a_d;
  logic              mem_we_q,  mem_we_d;
  logic [DATA_W-1:0] mem_din_q, mem_din_d;

  logic              rd_s1_q,      rd_s1_d;
  logic              vga_rvalid_q, vga_rvalid_d;
  logic [DATA_W-1:0] vga_rdata_q,  vga_rdata_d;

  // A writer counts as starved only while it is still asking; a stale full
  // counter from a request that was just dropped must not win a slot.
  always_comb begin
    ld_starved  = ld_req  && (ld_cnt_q  == LIMIT);
    hps_starved = hps_req && (hps_cnt_q == LIMIT);
  end

  // Pick the single owner of this cycle's memory slot.
  always_comb begin
    sel = SEL_NONE;
    if (ld_starved && hps_starved) begin
      sel = (rr_q == RR_LD) ? SEL_LD : SEL_HPS;
    end else if (ld_starved) begin
      sel = SEL_LD;
    end else if (hps_starved) begin
      sel = SEL_HPS;
    end else if (vga_req) begin
      sel = SEL_VGA;
    end else if (ld_req && hps_req) begin
      sel = (rr_q == RR_LD) ? SEL_LD : SEL_HPS;
    end else if (ld_req) begin
      sel = SEL_LD;
    end else if (hps_req) begin
      sel = SEL_HPS;
    end
  end

  // Starve counters count refused cycles and saturate at the limit.
  always_comb begin
    ld_cnt_d  = ld_cnt_q;
    hps_cnt_d = hps_cnt_q;

    if (!ld_req || sel == SEL_LD) begin
      ld_cnt_d = '0;
    end else if (ld_cnt_q != LIMIT) begin
      ld_cnt_d = ld_cnt_q + CNT_W'(1);
    end

    if (!hps_req || sel == SEL_HPS) begin
      hps_cnt_d = '0;
    end else if (hps_cnt_q != LIMIT) begin
      hps_cnt_d = hps_cnt_q + CNT_W'(1);
    end
  end

  // The pointer hands the next tie to the writer that was not just served.
  always_comb begin
    rr_d = rr_q;
    if (sel == SEL_LD) begin
      rr_d = RR_HPS;
    end else if (sel == SEL_HPS) begin
      rr_d = RR_LD;
    end
  end

  // Grant pulses and the memory command; address and data hold when idle.
  always_comb begin
    vga_gnt_d = (sel == SEL_VGA);
    ld_gnt_d  = (sel == SEL_LD);
    hps_gnt_d = (sel == SEL_HPS);
    mem_we_d  = (sel == SEL_LD) || (sel == SEL_HPS);
    mem_a_d   = mem_a_q;
    mem_din_d = mem_din_q;

    case (sel)
      SEL_VGA: begin
        mem_a_d = vga_addr;
      end
      SEL_LD: begin
        mem_a_d   = ld_addr;
        mem_din_d = ld_wdata;
      end
      SEL_HPS: begin
        mem_a_d   = hps_addr;
        mem_din_d = hps_wdata;
      end
      default: begin
        mem_a_d   = mem_a_q;
        mem_din_d = mem_din_q;
      end
    endcase
  end

  // The memory samples a read the edge after the grant; capture its output on
  // the edge after that, so every VGA grant turns into exactly one rvalid.
  always_comb begin
    rd_s1_d      = vga_gnt_q;
    vga_rvalid_d = rd_s1_q;
    vga_rdata_d  = vga_rdata_q;
    if (rd_s1_q) begin
      vga_rdata_d = mem_dout;
    end
  end

  // Arbitration state: round-robin pointer and starve counters.
  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      rr_q      <= RR_LD;
      ld_cnt_q  <= '0;
      hps_cnt_q <= '0;
    end else begin
      rr_q      <= rr_d;
      ld_cnt_q  <= ld_cnt_d;
      hps_cnt_q <= hps_cnt_d;
    end
  end

  // Registered grants and memory command.
  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      vga_gnt_q <= 1'b0;
      ld_gnt_q  <= 1'b0;
      hps_gnt_q <= 1'b0;
      mem_a_q   <= '0;
      mem_we_q  <= 1'b0;
      mem_din_q <= '0;
    end else begin
      vga_gnt_q <= vga_gnt_d;
      ld_gnt_q  <= ld_gnt_d;
      hps_gnt_q <= hps_gnt_d;
      mem_a_q   <= mem_a_d;
      mem_we_q  <= mem_we_d;
      mem_din_q <= mem_din_d;
    end
  end

  // Read-return pipeline; reset drops anything in flight.
  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      rd_s1_q      <= 1'b0;
      vga_rvalid_q <= 1'b0;
      vga_rdata_q  <= '0;
    end else begin
      rd_s1_q      <= rd_s1_d;
      vga_rvalid_q <= vga_rvalid_d;
      vga_rdata_q  <= vga_rdata_d;
    end
  end

  // Output wiring. The stall flag comes straight from this cycle's decision
  // and is forced low while reset is held so every output reads zero.
  always_comb begin
    vga_gnt    = vga_gnt_q;
    ld_gnt     = ld_gnt_q;
    hps_gnt    = hps_gnt_q;
    mem_a      = mem_a_q;
    mem_we     = mem_we_q;
    mem_din    = mem_din_q;
    vga_rvalid = vga_rvalid_q;
    vga_rdata  = vga_rdata_q;
    vga_stall  = vga_req && (sel != SEL_VGA) && !reset;
  end

endmodule
